bpu_upd_queue: RTL and testbench
================================

// Module: bpu_upd_queue
// PURPOSE
//  Buffers resolved-branch update records from the execution unit and replays them, one per cycle, onto the BPU update port.
//  The BPU update port carries the BTB clear, new-branch and mispredict updates and the gshare PHT update.
//  Sits between branch resolution (exu) and bpu_module; decouples resolution bursts from the single-ported BTB/PHT write path.
//  Holds drain while any pipeline flush is active, so no update is lost while the BPU gates its writes.
// PARAMETERS
//  UPDQ_DEPTH   4   entries; power of two, >= 2
//  UPDQ_PTR_W   2   log2(UPDQ_DEPTH); pointers carry one extra wrap bit internally
// PORTS
//  clk                 in   1            core clock
//  rst_n               in   1            asynchronous active-low reset
//  i_csr_trap_flush    in   1            flush source; holds drain
//  i_exu_mis_flush     in   1            flush source; holds drain
//  i_exu_ls_flush      in   1            flush source; holds drain
//  i_exu_updq_vld      in   1            enqueue request
//  o_updq_exu_rdy      out  1            queue can accept (= ~full)
//  i_exu_updq_rec      in   `BPU_UPD_REC_WIDTH   packed update record
//  o_iq_bpu_vld        out  1            head record valid to BPU
//  o_iq_bpu_taken      out  1            record fields to BPU, each unpacked from the head record:
//  o_iq_bpu_new_br     out  1             taken; new_br; btb_type
//  o_iq_bpu_btb_type   out  1
//  o_iq_bpu_btb_addr   out  `CORE_PC_WIDTH    btb_addr
//  o_iq_bpu_btb_taddr  out  `CORE_PC_WIDTH    btb_taddr
//  o_iq_bpu_btb_idx    out  `BTB_IDX_WIDTH    btb_idx
//  o_iq_bpu_pht_entry  out  2                 pht_entry
//  o_iq_bpu_pht_idx    out  `PHT_IDX_WIDTH    pht_idx
//  o_iq_bpu_alias_err  out  1                 alias_err
//  o_iq_bpu_tsucc      out  1                 tsucc
//  o_updq_cnt          out  UPDQ_PTR_W+1      current occupancy
//  o_updq_drop         out  1            sticky: an enqueue was attempted while full
// BEHAVIOUR
//  - Reset: rd/wr pointers 0, cnt 0, o_iq_bpu_vld 0, o_updq_exu_rdy 1, o_updq_drop 0; all record outputs 0.
//  - hold = trap | mis | ls flush. Flushes do NOT discard entries: updates are from resolved branches and stay valid.
//  - push = i_exu_updq_vld & ~full. pop = o_iq_bpu_vld & ~hold. The BPU always consumes a presented record in the cycle it is popped.
//  - Head outputs are driven from the entry at rd_ptr. o_iq_bpu_vld = ~empty (no bypass build).
//  - Latency: a record pushed in cycle N is visible on o_iq_bpu_* in cycle N+1 at the earliest.
//  - cnt' = cnt + push - pop. Pointers wrap modulo UPDQ_DEPTH; full/empty come from pointer MSB compare.
//  - Full: o_updq_exu_rdy = 0, registered from state. A pop in the same cycle does not raise rdy until the next cycle.
//  - Push while full: record discarded, o_updq_drop set. It stays set until reset.
//  - Push and pop in the same cycle at a non-boundary occupancy: both occur, cnt unchanged.
//  - Empty with push: the record is written; o_iq_bpu_vld rises the next cycle.
//  - Hold asserted: head stays stable, o_iq_bpu_vld stays 1 if non-empty, no pop. Pushes continue.
//  - Reset mid-operation: all entries invalidated immediately (async); o_updq_drop cleared.
// CONFIGURATION
//  BPU_UPDQ_BYPASS_EN defined:
//  - When empty and push & ~hold, the incoming record drives o_iq_bpu_* combinationally in the same cycle.
//  - o_iq_bpu_vld = 1 in that cycle, and the record is consumed without being written.
//  - When empty with push & hold, the record is written as usual.
//  BPU_UPDQ_BYPASS_EN undefined: strict registered path, 1-cycle minimum latency.
// STRUCTURE
//  - Shared defines: `BPU_UPD_REC_WIDTH, plus field LSB/MSB offsets for packing and unpacking.
//    Record order MSB->LSB: taken, new_br, btb_type, btb_addr, btb_taddr, btb_idx, pht_entry, pht_idx, alias_err, tsucc.
//    The exu packer and this unpacker both use these offsets.
//  - Sub-module bpu_updq_ram: UPDQ_DEPTH x `BPU_UPD_REC_WIDTH flop array.
//    1 write port (wr_en, wr_ptr, data) and 1 async read port (rd_ptr); no reset on the data array.
//  - Top level holds pointers, counter, drop flag, hold/bypass muxing, and field unpack.
// TESTING
//  1 Reset, then push one record {btb_idx=3, tsucc=1}:
//    o_iq_bpu_vld=1 with btb_idx=3 next cycle (same cycle with BYPASS_EN); popped; cnt returns to 0.
//  2 Push 4 records back-to-back with no pop (hold=1):
//    cnt=4 and rdy=0; a 5th push sets o_updq_drop=1 and cnt stays 4.
//  3 Full queue, release hold:
//    records drain in FIFO order, 1 per cycle, over 4 cycles; rdy=1 the cycle after the first pop.
//  4 i_exu_mis_flush pulsed for 2 cycles while 2 records are queued:
//    head stable and vld=1 for 2 cycles, no loss; drains afterwards.
//  5 Steady push+pop every cycle for 16 cycles at cnt=2:
//    cnt stays 2; pointers wrap 4 times; output order matches input order.
//  6 rst_n asserted with cnt=3 and drop=1:
//    vld=0, cnt=0, drop=0 immediately; first post-reset push is output first.

Source files
------------

// File: rtl/bpu_upd_queue_pkg.sv
// rtl/bpu_upd_queue_pkg.sv - BPU update record layout and update queue sizing
`ifndef BPU_UPD_QUEUE_DEFS
`define BPU_UPD_QUEUE_DEFS
`define CORE_PC_WIDTH 32
`define BTB_IDX_WIDTH 4
`define PHT_IDX_WIDTH 6
`define BPU_UPD_REC_WIDTH (3 + 2*`CORE_PC_WIDTH + `BTB_IDX_WIDTH + 2 + `PHT_IDX_WIDTH + 2)
// Record order MSB->LSB: taken, new_br, btb_type, btb_addr, btb_taddr, btb_idx, pht_entry, pht_idx, alias_err, tsucc
`define BPU_REC_TSUCC_BIT      0
`define BPU_REC_ALIAS_ERR_BIT  1
`define BPU_REC_PHT_IDX_LSB    2
`define BPU_REC_PHT_IDX_MSB    (`BPU_REC_PHT_IDX_LSB + `PHT_IDX_WIDTH - 1)
`define BPU_REC_PHT_ENTRY_LSB  (`BPU_REC_PHT_IDX_MSB + 1)
`define BPU_REC_PHT_ENTRY_MSB  (`BPU_REC_PHT_ENTRY_LSB + 1)
`define BPU_REC_BTB_IDX_LSB    (`BPU_REC_PHT_ENTRY_MSB + 1)
`define BPU_REC_BTB_IDX_MSB    (`BPU_REC_BTB_IDX_LSB + `BTB_IDX_WIDTH - 1)
`define BPU_REC_BTB_TADDR_LSB  (`BPU_REC_BTB_IDX_MSB + 1)
`define BPU_REC_BTB_TADDR_MSB  (`BPU_REC_BTB_TADDR_LSB + `CORE_PC_WIDTH - 1)
`define BPU_REC_BTB_ADDR_LSB   (`BPU_REC_BTB_TADDR_MSB + 1)
`define BPU_REC_BTB_ADDR_MSB   (`BPU_REC_BTB_ADDR_LSB + `CORE_PC_WIDTH - 1)
`define BPU_REC_BTB_TYPE_BIT   (`BPU_REC_BTB_ADDR_MSB + 1)
`define BPU_REC_NEW_BR_BIT     (`BPU_REC_BTB_TYPE_BIT + 1)
`define BPU_REC_TAKEN_BIT      (`BPU_REC_NEW_BR_BIT + 1)
`endif

package bpu_upd_queue_pkg;
   localparam int UPDQ_DEPTH_DEF = 4;
   localparam int UPDQ_PTR_W_DEF = 2;
   localparam int UPD_REC_W      = `BPU_UPD_REC_WIDTH;
endpackage

// File: rtl/bpu_updq_ram.sv
// rtl/bpu_updq_ram.sv - update queue storage: one write port, one async read port, no reset
module bpu_updq_ram #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int W     = 8
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_ptr,
   input  logic [W-1:0]     wr_data,
   input  logic [PTR_W-1:0] rd_ptr,
   output logic [W-1:0]     rd_data
);
   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr];
endmodule

// File: rtl/bpu_upd_queue.sv
// rtl/bpu_upd_queue.sv - resolved-branch update FIFO feeding the BPU update port
// BPU_UPDQ_BYPASS_EN: an empty, unheld queue forwards an incoming record in the same cycle.
module bpu_upd_queue
   import bpu_upd_queue_pkg::*;
#(
   parameter int UPDQ_DEPTH = UPDQ_DEPTH_DEF,
   parameter int UPDQ_PTR_W = UPDQ_PTR_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_csr_trap_flush,
   input  logic                          i_exu_mis_flush,
   input  logic                          i_exu_ls_flush,
   input  logic                          i_exu_updq_vld,
   output logic                          o_updq_exu_rdy,
   input  logic [`BPU_UPD_REC_WIDTH-1:0] i_exu_updq_rec,
   output logic                          o_iq_bpu_vld,
   output logic                          o_iq_bpu_taken,
   output logic                          o_iq_bpu_new_br,
   output logic                          o_iq_bpu_btb_type,
   output logic [`CORE_PC_WIDTH-1:0]     o_iq_bpu_btb_addr,
   output logic [`CORE_PC_WIDTH-1:0]     o_iq_bpu_btb_taddr,
   output logic [`BTB_IDX_WIDTH-1:0]     o_iq_bpu_btb_idx,
   output logic [1:0]                    o_iq_bpu_pht_entry,
   output logic [`PHT_IDX_WIDTH-1:0]     o_iq_bpu_pht_idx,
   output logic                          o_iq_bpu_alias_err,
   output logic                          o_iq_bpu_tsucc,
   output logic [UPDQ_PTR_W:0]           o_updq_cnt,
   output logic                          o_updq_drop
);
   logic [UPDQ_PTR_W:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                 drop_q, drop_d;
   logic                 hold, empty, full, push, pop, wr_en, bypass;
   logic [UPD_REC_W-1:0] ram_rd_data, head, rec_out;

   assign hold  = i_csr_trap_flush | i_exu_mis_flush | i_exu_ls_flush;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[UPDQ_PTR_W] != rd_ptr_q[UPDQ_PTR_W]) &&
                  (wr_ptr_q[UPDQ_PTR_W-1:0] == rd_ptr_q[UPDQ_PTR_W-1:0]);
   assign push  = i_exu_updq_vld & ~full;

`ifdef BPU_UPDQ_BYPASS_EN
   assign bypass = empty & push & ~hold;
`else
   assign bypass = 1'b0;
`endif

   assign o_iq_bpu_vld = ~empty | bypass;
   assign pop          = o_iq_bpu_vld & ~hold;
   // A bypassed record is consumed directly and never touches storage or pointers.
   assign wr_en        = push & ~bypass;
   assign head         = bypass ? i_exu_updq_rec : ram_rd_data;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      drop_d   = drop_q;
      if (wr_en)          wr_ptr_d = wr_ptr_q + (UPDQ_PTR_W+1)'(1);
      if (pop & ~bypass)  rd_ptr_d = rd_ptr_q + (UPDQ_PTR_W+1)'(1);
      if (i_exu_updq_vld & full) drop_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         drop_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         drop_q   <= drop_d;
      end
   end

   bpu_updq_ram #(
      .DEPTH (UPDQ_DEPTH),
      .PTR_W (UPDQ_PTR_W),
      .W     (UPD_REC_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_ptr  (wr_ptr_q[UPDQ_PTR_W-1:0]),
      .wr_data (i_exu_updq_rec),
      .rd_ptr  (rd_ptr_q[UPDQ_PTR_W-1:0]),
      .rd_data (ram_rd_data)
   );

   assign o_updq_cnt     = wr_ptr_q - rd_ptr_q;
   assign o_updq_exu_rdy = ~full;
   assign o_updq_drop    = drop_q;

   // Storage is unreset, so the record is masked whenever nothing valid is presented.
   assign rec_out = o_iq_bpu_vld ? head : '0;

   assign o_iq_bpu_taken     = rec_out[`BPU_REC_TAKEN_BIT];
   assign o_iq_bpu_new_br    = rec_out[`BPU_REC_NEW_BR_BIT];
   assign o_iq_bpu_btb_type  = rec_out[`BPU_REC_BTB_TYPE_BIT];
   assign o_iq_bpu_btb_addr  = rec_out[`BPU_REC_BTB_ADDR_MSB:`BPU_REC_BTB_ADDR_LSB];
   assign o_iq_bpu_btb_taddr = rec_out[`BPU_REC_BTB_TADDR_MSB:`BPU_REC_BTB_TADDR_LSB];
   assign o_iq_bpu_btb_idx   = rec_out[`BPU_REC_BTB_IDX_MSB:`BPU_REC_BTB_IDX_LSB];
   assign o_iq_bpu_pht_entry = rec_out[`BPU_REC_PHT_ENTRY_MSB:`BPU_REC_PHT_ENTRY_LSB];
   assign o_iq_bpu_pht_idx   = rec_out[`BPU_REC_PHT_IDX_MSB:`BPU_REC_PHT_IDX_LSB];
   assign o_iq_bpu_alias_err = rec_out[`BPU_REC_ALIAS_ERR_BIT];
   assign o_iq_bpu_tsucc     = rec_out[`BPU_REC_TSUCC_BIT];
endmodule

// File: tb/tb_bpu_upd_queue.sv
// tb/tb_bpu_upd_queue.sv - scoreboard bench for bpu_upd_queue with a FIFO reference model
module tb_bpu_upd_queue;
   import bpu_upd_queue_pkg::*;

   localparam int RW = `BPU_UPD_REC_WIDTH;
   localparam int PW = `CORE_PC_WIDTH;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          trap_f = 1'b0, mis_f = 1'b0, ls_f = 1'b0;
   logic          in_vld = 1'b0;
   logic [RW-1:0] in_rec = '0;
   logic          rdy, vld, taken, new_br, btb_type, alias_err, tsucc, drop;
   logic [PW-1:0] btb_addr, btb_taddr;
   logic [`BTB_IDX_WIDTH-1:0] btb_idx;
   logic [1:0]    pht_entry;
   logic [`PHT_IDX_WIDTH-1:0] pht_idx;
   logic [2:0]    cnt;

   always #5 clk = ~clk;

   bpu_upd_queue dut (
      .clk(clk), .rst_n(rst_n),
      .i_csr_trap_flush(trap_f), .i_exu_mis_flush(mis_f), .i_exu_ls_flush(ls_f),
      .i_exu_updq_vld(in_vld), .o_updq_exu_rdy(rdy), .i_exu_updq_rec(in_rec),
      .o_iq_bpu_vld(vld), .o_iq_bpu_taken(taken), .o_iq_bpu_new_br(new_br),
      .o_iq_bpu_btb_type(btb_type), .o_iq_bpu_btb_addr(btb_addr),
      .o_iq_bpu_btb_taddr(btb_taddr), .o_iq_bpu_btb_idx(btb_idx),
      .o_iq_bpu_pht_entry(pht_entry), .o_iq_bpu_pht_idx(pht_idx),
      .o_iq_bpu_alias_err(alias_err), .o_iq_bpu_tsucc(tsucc),
      .o_updq_cnt(cnt), .o_updq_drop(drop)
   );

   // Reference model: ordered list of accepted records plus the sticky drop flag.
   logic [RW-1:0] sb[$];
   bit  model_drop = 0;
   int  cnt_start  = 0;
   bit  push_now   = 0;
   bit  hold_now   = 0;
   bit  active     = 0;
   int  checks = 0, passed = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [RW-1:0] mk_rec(input bit tk, input bit nb, input bit ty,
         input logic [PW-1:0] a, input logic [PW-1:0] ta, input logic [3:0] bi,
         input logic [1:0] pe, input logic [5:0] pi, input bit ae, input bit ts);
      return {tk, nb, ty, a, ta, bi, pe, pi, ae, ts};
   endfunction

   function automatic logic [RW-1:0] rnd_rec();
      return RW'({$urandom(), $urandom(), $urandom()});
   endfunction

   // One cycle of stimulus: check registered state, then drive and update the model.
   task automatic cyc(input bit v, input logic [RW-1:0] r, input bit t, input bit m, input bit l);
      @(posedge clk); #1;
      cnt_start = sb.size();
      chk("cnt", cnt, cnt_start);
      chk("rdy", rdy, cnt_start < D);
      chk("drop", drop, model_drop);
      in_vld = v; in_rec = r; trap_f = t; mis_f = m; ls_f = l;
      hold_now = t | m | l;
      push_now = v && (cnt_start < D);
      if (v && cnt_start >= D) model_drop = 1;
      if (push_now) sb.push_back(r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0);
   endtask

   // Monitor: compares the presented head against the oldest outstanding record.
   initial begin
      logic [RW-1:0] act;
      bit            exp_vld;
      forever begin
         @(negedge clk);
         if (rst_n && active) begin
            exp_vld = cnt_start > 0;
`ifdef BPU_UPDQ_BYPASS_EN
            if (cnt_start == 0 && push_now && !hold_now) exp_vld = 1;
`endif
            chk("vld", vld, exp_vld);
            act = {taken, new_br, btb_type, btb_addr, btb_taddr, btb_idx,
                   pht_entry, pht_idx, alias_err, tsucc};
            if (exp_vld && sb.size() > 0) begin
               chk("head", act, sb[0]);
               if (!hold_now) void'(sb.pop_front());
            end else begin
               chk("idle_rec", act, '0);
            end
         end
      end
   end

   initial begin
      logic [RW-1:0] r;
      #12;
      chk("rst_vld", vld, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_rdy", rdy, 1);
      chk("rst_drop", drop, 0);
      chk("rst_idx", btb_idx, 0);
      rst_n = 1'b1;
      active = 1;

      // single record with btb_idx=3, tsucc=1
      r = mk_rec(0, 0, 0, '0, '0, 4'd3, 2'd0, 6'd0, 0, 1);
      cyc(1, r, 0, 0, 0);
      idle(3);

      // fill under hold, overflow, then release
      for (int i = 0; i < 5; i++) cyc(1, rnd_rec(), 0, 1, 0);
      cyc(0, '0, 1, 0, 0);
      idle(6);

      // two queued, mispredict flush held for two cycles
      cyc(1, rnd_rec(), 0, 0, 1);
      cyc(1, rnd_rec(), 0, 0, 1);
      cyc(0, '0, 0, 1, 0);
      cyc(0, '0, 0, 1, 0);
      idle(4);

      // steady push+pop at occupancy 2
      cyc(1, rnd_rec(), 1, 0, 0);
      cyc(1, rnd_rec(), 1, 0, 0);
      for (int i = 0; i < 16; i++) cyc(1, rnd_rec(), 0, 0, 0);
      idle(4);

      // reset with cnt=3 and drop=1
      for (int i = 0; i < 5; i++) cyc(1, rnd_rec(), 0, 1, 0);
      cyc(0, '0, 0, 0, 0);
      @(posedge clk); #1;
      chk("pre_rst_cnt", cnt, 3);
      rst_n = 1'b0;
      in_vld = 0; trap_f = 0; mis_f = 0; ls_f = 0;
      #1;
      chk("mid_rst_vld", vld, 0);
      chk("mid_rst_cnt", cnt, 0);
      chk("mid_rst_drop", drop, 0);
      sb.delete();
      model_drop = 0; cnt_start = 0; push_now = 0; hold_now = 0;
      #1 rst_n = 1'b1;
      r = mk_rec(1, 1, 1, 32'hDEAD_BEEF, 32'h1234_5678, 4'd9, 2'd2, 6'd33, 1, 0);
      cyc(1, r, 0, 0, 0);
      cyc(1, rnd_rec(), 0, 0, 0);
      idle(4);

      // randomized traffic with random flushes
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 9) < 6, rnd_rec(), $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      idle(8);
      chk("final_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
